// File: rtl/clock_route_pkg.sv
// Shared types and defaults for the clock-route enable requester.
package clock_route_pkg;

  typedef enum logic [1:0] {
    OFF         = 2'd0,
    TURNING_ON  = 2'd1,
    ON          = 2'd2,
    TURNING_OFF = 2'd3
  } route_state_t;

  localparam int CLOCK_ROUTE_SYNC_STAGES_DEFAULT = 2;
  localparam int CLOCK_ROUTE_TIMEOUT_DEFAULT     = 1024;

endpackage

// File: rtl/clock_route_ack_sync.sv
// Multi-flop synchronizer for the far-domain ack level; SYNC_STAGES cycles latency, no backpressure.
module clock_route_ack_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic resetn,
  input  logic ack,
  output logic ack_s
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], ack};
    end
  end

  assign ack_s = chain[SYNC_STAGES-1];

endmodule

// File: rtl/clock_route_enable_requester.sv
// Turns on/off pulses into a four-phase enable/ack handshake with a sticky timeout flag.
// Outputs registered; requests arriving mid-transition are dropped rather than queued.
module clock_route_enable_requester
  import clock_route_pkg::*;
#(
  parameter int SYNC_STAGES    = CLOCK_ROUTE_SYNC_STAGES_DEFAULT,
  parameter int TIMEOUT_CYCLES = CLOCK_ROUTE_TIMEOUT_DEFAULT
) (
  input  logic clock,
  input  logic resetn,
  input  logic req_on,
  input  logic req_off,
  input  logic err_clear,
  output logic async_enable,
  input  logic async_enable_ack,
  output logic route_enabled,
  output logic busy,
  output logic timeout_err
);

  localparam int TIMEOUT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  route_state_t         state;
  logic [TIMEOUT_W-1:0] cnt;
  logic                 ack_s;

  clock_route_ack_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clock (clock),
    .resetn(resetn),
    .ack   (async_enable_ack),
    .ack_s (ack_s)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state         <= OFF;
      cnt           <= '0;
      async_enable  <= 1'b0;
      route_enabled <= 1'b0;
      busy          <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      // A timeout raised below on this same edge overrides the clear.
      if (err_clear) begin
        timeout_err <= 1'b0;
      end

      case (state)
        OFF: begin
          if (req_on && !req_off && !timeout_err) begin
            state        <= TURNING_ON;
            async_enable <= 1'b1;
            busy         <= 1'b1;
            cnt          <= '0;
          end
        end

        TURNING_ON: begin
          if (ack_s) begin
            state         <= ON;
            route_enabled <= 1'b1;
            busy          <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state        <= TURNING_OFF;
            async_enable <= 1'b0;
            timeout_err  <= 1'b1;
            cnt          <= '0;
          end else begin
            cnt <= cnt + TIMEOUT_W'(1);
          end
        end

        ON: begin
          // The ack level is not watched here: only an explicit req_off leaves ON.
          if (req_off) begin
            state         <= TURNING_OFF;
            async_enable  <= 1'b0;
            route_enabled <= 1'b0;
            busy          <= 1'b1;
            cnt           <= '0;
          end
        end

        TURNING_OFF: begin
          if (!ack_s) begin
            state <= OFF;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state       <= OFF;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            cnt <= cnt + TIMEOUT_W'(1);
          end
        end

        default: begin
          state         <= OFF;
          async_enable  <= 1'b0;
          route_enabled <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule
